// File: rtl/iterative_alu.sv
// iterative_alu: handshaked ALU; single-cycle ops finish in one cycle, MUL/DIVU/REMU iterate one bit per cycle
module iterative_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_select,
    input  logic [WIDTH-1:0] alu_in_1,
    input  logic [WIDTH-1:0] alu_in_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_bcond
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
    logic               bcond_q, bcond_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [SHAMT_W-1:0] sh;
    logic [WIDTH-1:0]   sc_res, mul_acc, div_rem, div_quo;
    logic [WIDTH:0]     r_sh, diff;
    logic               sc_bc, ge, go_busy, last;

    assign sh      = alu_in_2[SHAMT_W-1:0];
    assign go_busy = alu_select == 4'hD || (alu_select[3:1] == 3'b111 && |alu_in_2);
    assign last    = cnt_q == SHAMT_W'(WIDTH - 1);

    // DIVU/REMU only reach this decode with a zero divisor
    always_comb begin
        sc_res = '0;
        sc_bc  = 1'b0;
        case (alu_select)
            4'h0: sc_res = alu_in_1 + alu_in_2;
            4'h1: sc_res = alu_in_1 - alu_in_2;
            4'h2: sc_res = alu_in_1 << sh;
            4'h3: sc_res = alu_in_1 ^ alu_in_2;
            4'h4: sc_res = alu_in_1 | alu_in_2;
            4'h5: sc_res = alu_in_1 & alu_in_2;
            4'h6: sc_res = alu_in_1 >> sh;
            4'h7: sc_bc  = alu_in_1 == alu_in_2;
            4'h8: sc_bc  = alu_in_1 != alu_in_2;
            4'h9: sc_bc  = alu_in_1 < alu_in_2;
            4'hA: sc_bc  = alu_in_1 >= alu_in_2;
            4'hB: sc_res = $signed(alu_in_1) >>> sh;
            4'hC: sc_bc  = $signed(alu_in_1) < $signed(alu_in_2);
            4'hE: sc_res = '1;
            4'hF: sc_res = alu_in_1;
            default: ;
        endcase
    end

    // acc_q is the product accumulator for MUL and the partial remainder for division
    assign mul_acc = acc_q + (b_q[0] ? a_q : '0);
    assign r_sh    = {acc_q, a_q[WIDTH-1]};
    assign diff    = r_sh - {1'b0, b_q};
    assign ge      = ~diff[WIDTH];
    assign div_rem = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    assign div_quo = {a_q[WIDTH-2:0], ge};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        bcond_d = bcond_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d    = alu_select;
                a_d     = alu_in_1;
                b_d     = alu_in_2;
                acc_d   = '0;
                cnt_d   = '0;
                res_d   = sc_res;
                bcond_d = sc_bc;
                state_d = go_busy ? BUSY : DONE;
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = op_q == 4'hD ? mul_acc : div_rem;
                a_d   = op_q == 4'hD ? a_q << 1 : div_quo;
                b_d   = op_q == 4'hD ? b_q >> 1 : b_q;
                if (last) begin
                    state_d = DONE;
                    bcond_d = 1'b0;
                    res_d   = op_q == 4'hD ? mul_acc : op_q == 4'hE ? div_quo : div_rem;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            bcond_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            bcond_q <= bcond_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign alu_result = out_valid ? res_q : '0;
    assign alu_bcond  = out_valid & bcond_q;
endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: directed vector table plus backpressure and reset-abort sequences
module tb_iterative_alu;
    logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic [3:0]  alu_select = 0;
    logic [31:0] alu_in_1 = 0, alu_in_2 = 0;
    logic        in_ready, out_valid, alu_bcond;
    logic [31:0] alu_result;
    int passed = 0, total = 0;
    int lat, zv;

    iterative_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_select(alu_select), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .alu_bcond(alu_bcond)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a, b, res;
        logic        bc;
        int          lat;
    } vec_t;
    vec_t v[20];

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", n, act, exp);
        else passed++;
    endtask

    // operands are scrambled and in_valid held high afterwards; the DUT must ignore them
    task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        alu_select = s;
        alu_in_1   = a;
        alu_in_2   = b;
        in_valid   = 1;
        @(posedge clk); #1;
        alu_select = 4'($urandom);
        alu_in_1   = $urandom;
        alu_in_2   = $urandom;
    endtask

    task automatic wait_done();
        lat = 1;
        zv  = 0;
        while (!out_valid && lat < 100) begin
            if (alu_result != 0 || alu_bcond || in_ready) zv++;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 0;
    endtask

    task automatic release_out(input string n);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check({n, " idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        v[0]  = '{4'h0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1};
        v[1]  = '{4'h1, 32'h3,        32'h5,        32'hFFFFFFFE, 1'b0, 1};
        v[2]  = '{4'h2, 32'h1,        32'h21,       32'h2,        1'b0, 1};
        v[3]  = '{4'h3, 32'hF0F0,     32'hFF00,     32'h0FF0,     1'b0, 1};
        v[4]  = '{4'h4, 32'hF0,       32'h0F,       32'hFF,       1'b0, 1};
        v[5]  = '{4'h5, 32'hF0,       32'h3C,       32'h30,       1'b0, 1};
        v[6]  = '{4'h6, 32'h80000000, 32'h4,        32'h08000000, 1'b0, 1};
        v[7]  = '{4'h7, 32'h5,        32'h5,        32'h0,        1'b1, 1};
        v[8]  = '{4'h8, 32'h5,        32'h5,        32'h0,        1'b0, 1};
        v[9]  = '{4'h9, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1};
        v[10] = '{4'hA, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1};
        v[11] = '{4'hB, 32'h80000000, 32'h24,       32'hF8000000, 1'b0, 1};
        v[12] = '{4'hC, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1};
        v[13] = '{4'hD, 32'h00010001, 32'h00010001, 32'h00020001, 1'b0, 33};
        v[14] = '{4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 33};
        v[15] = '{4'hE, 32'd100,      32'd7,        32'd14,       1'b0, 33};
        v[16] = '{4'hF, 32'd100,      32'd7,        32'd2,        1'b0, 33};
        v[17] = '{4'hE, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1};
        v[18] = '{4'hF, 32'd5,        32'd0,        32'd5,        1'b0, 1};
        v[19] = '{4'hE, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 1'b0, 33};

        repeat (2) @(posedge clk);
        #1 reset = 0;
        check("reset", {in_ready, out_valid, alu_bcond, alu_result}, {3'b100, 32'h0});

        for (int i = 0; i < 20; i++) begin
            issue(v[i].sel, v[i].a, v[i].b);
            wait_done();
            check($sformatf("v%0d result", i), alu_result, v[i].res);
            check($sformatf("v%0d bcond", i), alu_bcond, v[i].bc);
            check($sformatf("v%0d latency", i), lat, v[i].lat);
            check($sformatf("v%0d quiet while pending", i), zv, 0);
            release_out($sformatf("v%0d", i));
        end

        issue(4'h0, 32'd7, 32'd8);
        wait_done();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d", k), {out_valid, in_ready, alu_result}, {2'b10, 32'd15});
            @(posedge clk); #1;
        end
        release_out("hold");

        issue(4'hD, 32'h12345, 32'h6789);
        repeat (9) @(posedge clk);
        #1 reset = 1;
        alu_select = 4'h0;
        alu_in_1   = 32'd1;
        alu_in_2   = 32'd1;
        @(posedge clk); #1;
        reset    = 0;
        in_valid = 0;
        check("abort", {in_ready, out_valid}, 2'b10);
        zv = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) zv++;
        end
        check("abort silent", zv, 0);

        issue(4'h0, 32'd2, 32'd3);
        wait_done();
        check("post-reset add", {alu_result, lat}, {32'd5, 32'd1});
        release_out("post-reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
